// File: rtl/btn_event_queue_if.sv
// rtl/btn_event_queue_if.sv - event head handshake between queue and consumer
interface btn_event_queue_if #(
    parameter int CODE_W = 2
);
    logic              evt_valid;
    logic              evt_ready;
    logic [CODE_W-1:0] evt_code;

    modport master (
        output evt_valid,
        output evt_code,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        output evt_ready
    );
endinterface

// File: rtl/btn_event_queue.sv
// rtl/btn_event_queue.sv - serialises debounced button pulses into a FWFT event FIFO
module btn_event_queue #(
    parameter int NUM_BTN    = 4,
    parameter int FIFO_DEPTH = 8,
    localparam int CODE_W    = $clog2(NUM_BTN),
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_pulse,
    btn_event_queue_if.master  evt,
    output logic [CNT_W-1:0]   evt_count,
    output logic               overflow,
    input  logic               clr_overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [NUM_BTN-1:0] pend_q, pend_d;
    logic [CODE_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;

    logic [CODE_W-1:0]  sel;
    logic [NUM_BTN-1:0] push_mask;
    logic [NUM_BTN-1:0] keep;
    logic               push;
    logic               pop;
    logic               drop;

    // Lowest pending index wins the single push slot this cycle
    always_comb begin
        sel = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel = CODE_W'(i);
            end
        end
    end

    // Handshake, pending update, drop detection and occupancy next-state
    always_comb begin
        pop        = (count_q != '0) && evt.evt_ready;
        push       = (|pend_q) && ((count_q < CNT_W'(FIFO_DEPTH)) || pop);
        push_mask  = push ? (NUM_BTN'(1) << sel) : '0;
        // A bit being pushed this edge is free to take a fresh press
        keep       = pend_q & ~push_mask;
        pend_d     = keep | btn_pulse;
        drop       = |(keep & btn_pulse);
        // A drop on the same edge as a clear keeps the flag set
        overflow_d = drop | (overflow_q & ~clr_overflow);
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // State registers; reset discards pending and queued events
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (push) begin
                mem_q[wr_ptr_q] <= sel;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Head is shown straight from registered state; code reads zero when empty
    always_comb begin
        evt.evt_valid = (count_q != '0);
        evt.evt_code  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
        evt_count     = count_q;
        overflow      = overflow_q;
    end
endmodule

// File: tb/tb_btn_event_queue.sv
// tb/tb_btn_event_queue.sv - self-checking bench for btn_event_queue
module tb_btn_event_queue;
    logic       clk;
    logic       rst_n;
    logic [3:0] btn_pulse;
    logic       evt_ready;
    logic       clr_overflow;
    logic [3:0] evt_count;
    logic       overflow;

    int checks;
    int errors;

    btn_event_queue_if #(.CODE_W(2)) evt_if ();
    assign evt_if.evt_ready = evt_ready;

    btn_event_queue #(.NUM_BTN(4), .FIFO_DEPTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_pulse    (btn_pulse),
        .evt          (evt_if.master),
        .evt_count    (evt_count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending presses as a set, queued events as a queue
    bit [3:0] m_pend;
    int       m_q[$];
    bit       m_ovf;

    task automatic model_edge(input logic [3:0] p, input logic rdy, input logic clr, input logic rst);
        bit       do_pop;
        bit       do_push;
        int       first;
        bit       dropped;
        bit [3:0] nxt;
        if (!rst) begin
            m_pend = '0;
            m_q.delete();
            m_ovf = 0;
            return;
        end
        do_pop  = (m_q.size() > 0) && rdy;
        do_push = (m_pend != 0) && ((m_q.size() < 8) || do_pop);
        first   = -1;
        for (int i = 0; i < 4; i++) begin
            if (first < 0 && m_pend[i]) first = i;
        end
        if (do_pop) void'(m_q.pop_front());
        if (do_push) m_q.push_back(first);
        dropped = 0;
        for (int i = 0; i < 4; i++) begin
            bit still_waiting;
            still_waiting = m_pend[i] && !(do_push && first == i);
            if (p[i] && still_waiting) dropped = 1;
            nxt[i] = still_waiting || p[i];
        end
        m_pend = nxt;
        if (dropped) m_ovf = 1;
        else if (clr) m_ovf = 0;
    endtask

    task automatic step(input logic [3:0] p, input logic rdy, input logic clr, input logic rst);
        btn_pulse    = p;
        evt_ready    = rdy;
        clr_overflow = clr;
        rst_n        = rst;
        @(posedge clk);
        model_edge(p, rdy, clr, rst);
        #1;
        btn_pulse    = '0;
        evt_ready    = 1'b0;
        clr_overflow = 1'b0;
        rst_n        = 1'b1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_reset;
        step(4'b1111, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        checks++;
        if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", evt_if.evt_valid); end
        checks++;
        if (evt_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", evt_count); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
        checks++;
        if (evt_if.evt_code !== 2'd0) begin errors++; $display("FAIL reset_code got %0d want 0", evt_if.evt_code); end
    endtask

    task automatic test_single_press;
        step(4'b0100, 1'b1, 1'b0, 1'b1);
        checks++;
        if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL single_early got %0b want 0", evt_if.evt_valid); end
        step(4'b0000, 1'b1, 1'b0, 1'b1);
        checks++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_code !== 2'd2) begin
            errors++; $display("FAIL single_head got valid=%0b code=%0d want valid=1 code=2", evt_if.evt_valid, evt_if.evt_code);
        end
        step(4'b0000, 1'b1, 1'b0, 1'b1);
        checks++;
        if (evt_if.evt_valid !== 1'b0 || evt_count !== 4'd0) begin
            errors++; $display("FAIL single_after got valid=%0b count=%0d want 0 0", evt_if.evt_valid, evt_count);
        end
    endtask

    task automatic test_simultaneous;
        int exp_codes[3] = '{0, 1, 3};
        step(4'b1011, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            step(4'b0000, 1'b0, 1'b0, 1'b1);
            checks++;
            if (evt_count !== 4'(k)) begin errors++; $display("FAIL simul_count got %0d want %0d", evt_count, k); end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (evt_if.evt_code !== 2'(exp_codes[k])) begin
                errors++; $display("FAIL simul_order got %0d want %0d", evt_if.evt_code, exp_codes[k]);
            end
            step(4'b0000, 1'b1, 1'b0, 1'b1);
        end
        checks++;
        if (overflow !== 1'b0 || evt_count !== 4'd0) begin
            errors++; $display("FAIL simul_end got ovf=%0b count=%0d want 0 0", overflow, evt_count);
        end
    endtask

    task automatic test_full_fifo;
        for (int k = 0; k < 8; k++) begin
            step(4'b0010, 1'b0, 1'b0, 1'b1);
            step(4'b0000, 1'b0, 1'b0, 1'b1);
            step(4'b0000, 1'b0, 1'b0, 1'b1);
        end
        checks++;
        if (evt_count !== 4'd8) begin errors++; $display("FAIL full_count got %0d want 8", evt_count); end
        step(4'b0100, 1'b0, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0, 1'b1);
        checks++;
        if (evt_count !== 4'd8 || overflow !== 1'b0) begin
            errors++; $display("FAIL full_hold got count=%0d ovf=%0b want 8 0", evt_count, overflow);
        end
        step(4'b0000, 1'b1, 1'b0, 1'b1);
        checks++;
        if (evt_count !== 4'd8) begin errors++; $display("FAIL full_pushpop got %0d want 8", evt_count); end
        for (int k = 0; k < 8; k++) begin
            logic [1:0] want;
            want = (k < 7) ? 2'd1 : 2'd2;
            checks++;
            if (evt_if.evt_valid !== 1'b1 || evt_if.evt_code !== want) begin
                errors++; $display("FAIL full_order idx=%0d got valid=%0b code=%0d want 1 %0d", k, evt_if.evt_valid, evt_if.evt_code, want);
            end
            step(4'b0000, 1'b1, 1'b0, 1'b1);
        end
        checks++;
        if (evt_count !== 4'd0) begin errors++; $display("FAIL full_drained got %0d want 0", evt_count); end
    endtask

    task automatic test_overflow;
        for (int k = 0; k < 8; k++) begin
            step(4'b0010, 1'b0, 1'b0, 1'b1);
            step(4'b0000, 1'b0, 1'b0, 1'b1);
        end
        checks++;
        if (evt_count !== 4'd8) begin errors++; $display("FAIL ovf_fill got %0d want 8", evt_count); end
        step(4'b0001, 1'b0, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_first got %0b want 0", overflow); end
        step(4'b0001, 1'b0, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_second got %0b want 1", overflow); end
        step(4'b0001, 1'b0, 1'b1, 1'b1);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_clr_drop got %0b want 1", overflow); end
        step(4'b0000, 1'b0, 1'b1, 1'b1);
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %0b want 0", overflow); end
        drain(12);
        checks++;
        if (evt_count !== 4'd0) begin errors++; $display("FAIL ovf_drained got %0d want 0", evt_count); end
    endtask

    task automatic test_repress;
        step(4'b1000, 1'b0, 1'b0, 1'b1);
        step(4'b1000, 1'b0, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0, 1'b1);
        checks++;
        if (evt_count !== 4'd2 || overflow !== 1'b0) begin
            errors++; $display("FAIL repress_count got count=%0d ovf=%0b want 2 0", evt_count, overflow);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (evt_if.evt_code !== 2'd3) begin errors++; $display("FAIL repress_code got %0d want 3", evt_if.evt_code); end
            step(4'b0000, 1'b1, 1'b0, 1'b1);
        end
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 5; k++) begin
            step(4'(1 << $urandom_range(0, 3)), 1'b0, 1'b0, 1'b1);
            step(4'b0000, 1'b0, 1'b0, 1'b1);
        end
        step(4'b0000, 1'b0, 1'b1, 1'b1);
        checks++;
        if (evt_count !== 4'd5) begin errors++; $display("FAIL mid_fill got %0d want 5", evt_count); end
        step(4'b0000, 1'b1, 1'b0, 1'b0);
        checks++;
        if (evt_if.evt_valid !== 1'b0 || evt_count !== 4'd0 || overflow !== 1'b0) begin
            errors++; $display("FAIL mid_reset got valid=%0b count=%0d ovf=%0b want 0 0 0", evt_if.evt_valid, evt_count, overflow);
        end
        test_single_press();
    endtask

    task automatic test_random;
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] p;
            logic       rdy;
            logic       clr;
            logic [1:0] want_code;
            p   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            rdy = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 25) == 0);
            step(p, rdy, clr, 1'b1);
            want_code = (m_q.size() > 0) ? 2'(m_q[0]) : 2'd0;
            checks++;
            if (evt_if.evt_valid !== (m_q.size() > 0) || evt_count !== 4'(m_q.size()) ||
                overflow !== m_ovf || evt_if.evt_code !== want_code) begin
                errors++;
                $display("FAIL random cyc=%0d got valid=%0b count=%0d code=%0d ovf=%0b want valid=%0b count=%0d code=%0d ovf=%0b",
                         c, evt_if.evt_valid, evt_count, evt_if.evt_code, overflow,
                         (m_q.size() > 0), m_q.size(), want_code, m_ovf);
            end
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        m_pend       = '0;
        m_ovf        = 0;
        rst_n        = 1'b0;
        btn_pulse    = '0;
        evt_ready    = 1'b0;
        clr_overflow = 1'b0;
        test_reset();
        test_single_press();
        test_simultaneous();
        test_full_fifo();
        test_overflow();
        test_repress();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout got no summary want finish");
        $fatal(1, "timeout");
    end
endmodule
